node_sequencer: RTL and testbench
=================================

# node_sequencer

Control FSM that time-multiplexes a single `node` MAC/activation datapath across `NUM_PASSES` neurons of a layer. It accepts one input vector per handshake and, for each pass, clears the node accumulator and steps `cnt_val` through all inputs. It then presents the activated result downstream with a valid/ready handshake. `pass_idx` selects the coefficient bank driven onto the node's `coef` port.

## Interface
- `NUM_INPUTS`, 64: elements accumulated per pass; range 2..64.
- `NUM_PASSES`, 16: neurons evaluated per accepted input vector; range 1..16.
- `CNT_W`, 7: width of `cnt_val`; must satisfy 2^CNT_W > NUM_INPUTS.
- `clk` in 1: single clock; all state updates on the rising edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: the upstream input vector is present on the node's `data_in`.
- `in_ready` out 1: the sequencer can accept a vector; high only in IDLE.
- `abort` in 1: synchronous cancel; returns the sequencer to IDLE.
- `reset_acc` out 1: drives the node's `reset_acc` pin.
- `hold` out 1: drives the node's `start` pin; 1 freezes the accumulator, 0 accumulates.
- `cnt_val` out CNT_W: element index driven to the node.
- `pass_idx` out 4: coefficient bank and neuron index of the current pass.
- `out_valid` out 1: the node's `node_out` holds the final result of the current pass.
- `out_ready` in 1: downstream consumes the result.
- `out_last` out 1: qualifies `out_valid`; high on the final pass.
- `busy` out 1: high in any state other than IDLE.
- `pause` in 1: present only with `NODE_SEQ_PAUSE_EN`.

## Operation
- The state register holds IDLE, CLEAR, ACCUM or DONE. `cnt_val` and `pass_idx` are registered. All other outputs decode from the state.
- **IDLE**
  - Outputs: `in_ready`=1, `hold`=1, `reset_acc`=0.
  - `in_valid`=1 moves to CLEAR, with `cnt_val`=0 and `pass_idx`=0.
- **CLEAR**
  - Outputs: `reset_acc`=1, `hold`=1.
  - Always moves to ACCUM after one cycle.
- **ACCUM**
  - Outputs: `hold`=0, `reset_acc`=0.
  - `cnt_val` increments every cycle.
  - When `cnt_val`==NUM_INPUTS-1, that edge moves to DONE and `cnt_val` wraps to 0.
- **DONE**
  - Outputs: `hold`=1, `out_valid`=1, `out_last`=(pass_idx==NUM_PASSES-1).
  - `out_ready`=1 with a non-last pass: increment `pass_idx` and move to CLEAR.
  - `out_ready`=1 on the last pass: move to IDLE and clear `pass_idx` to 0.
  - `out_ready`=0: stay in DONE with all outputs stable. `hold`=1 keeps `node_out` frozen.
- **Abort**
  - `abort`=1 in any state gives IDLE on the next edge, with `cnt_val`=0 and `pass_idx`=0.
  - `abort` has priority over all other transitions, including a simultaneous `out_ready` or `in_valid`.
- **Upstream contract:** `data_in` stays stable from acceptance until the final DONE handshake. The sequencer does not check this.
- **Counter rules:** counters saturate by construction and never exceed NUM_INPUTS-1 or NUM_PASSES-1. With NUM_PASSES=1, every DONE asserts `out_last`.

## Timing
- **Reset values (`n_rst`=0):** state IDLE, `in_ready`=1, `hold`=1, `reset_acc`=0, `cnt_val`=0, `pass_idx`=0, `out_valid`=0, `out_last`=0, `busy`=0.
- **Reset mid-pass:** reset takes effect immediately and asynchronously, to the same values.
- **Latency:** handshake at edge k gives CLEAR in cycle k+1, ACCUM in cycles k+2 .. k+1+NUM_INPUTS, and `out_valid` from cycle k+2+NUM_INPUTS.
- **Pass duration:** each pass takes NUM_INPUTS+2 cycles when `out_ready` is held high. A full vector takes NUM_PASSES*(NUM_INPUTS+2) cycles.
- **Accumulator contract:** `reset_acc` is high for exactly one cycle per pass. `hold` is low for exactly NUM_INPUTS cycles per pass when there is no pause.
- **Back-to-back vectors:** the earliest next acceptance is the cycle after the last DONE handshake; there is one IDLE cycle between vectors.

## Configuration
- **`NODE_SEQ_PAUSE_EN` defined:**
  - The `pause` port exists.
  - In ACCUM, `pause`=1 forces `hold`=1 and freezes `cnt_val`. Accumulation resumes at the same index when `pause`=0.
  - `pause` is ignored in the other states.
  - `abort` overrides `pause`.
- **`NODE_SEQ_PAUSE_EN` undefined:** the port is absent and ACCUM never stalls.

## Structure
- Shared package `nn_pkg` holds:
  - the state enum `seq_state_t` (IDLE, CLEAR, ACCUM, DONE);
  - constants `NN_NUM_INPUTS`=64 and `NN_NUM_PASSES`=16;
  - the `double` typedef, moved into the package.
- Sub-module `seq_counter`: a parameterised wrap counter with `clear`, `enable`, `rollover_val`, `count` and `rollover_flag`. It is instantiated twice: element index and pass index.

## Test plan
- **Reset:** hold `n_rst` low, then release → all outputs at their reset values and `in_ready`=1.
- **Single vector:** NUM_INPUTS=64, NUM_PASSES=1, `out_ready`=1, handshake at cycle 0 → `reset_acc` high in cycle 1, `cnt_val` 0..63 in cycles 2..65, `out_valid`=`out_last`=1 in cycle 66, IDLE in cycle 67.
- **Multiple passes with backpressure:** NUM_PASSES=3, `out_ready` low for 5 cycles in each DONE → `pass_idx` 0,1,2, `node_out` stable while waiting, `out_last` only on pass 2.
- **Abort:** `abort` when `cnt_val`=30 in pass 1 → IDLE next cycle with `cnt_val`=0, `pass_idx`=0, `out_valid` never asserted.
- **Pause (macro on):** `pause` high for 4 cycles at `cnt_val`=10 → `hold`=1 and `cnt_val`=10 for 4 cycles; total pass length 70 cycles.
- **Async reset mid-pass:** `n_rst` pulse during ACCUM → immediate return to IDLE; a new vector is then accepted normally.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and constants for the neural-node control blocks.
package nn_pkg;

  localparam int unsigned NN_NUM_INPUTS = 64;
  localparam int unsigned NN_NUM_PASSES = 16;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StAccum,
    StDone
  } seq_state_t;

  typedef real double;

endpackage

// File: rtl/seq_counter.sv
// Wrap counter: counts 0..rollover_val while enabled, then returns to 0.
module seq_counter
  import nn_pkg::*;
#(
  parameter int unsigned Width = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] rollover_val,
  output logic [Width-1:0] count,
  output logic             rollover_flag
);

  logic [Width-1:0] count_q, count_d;

  assign rollover_flag = (count_q == rollover_val);
  assign count         = count_q;

  // clear wins over enable so an abort always lands on zero
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = rollover_flag ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/node_sequencer.sv
// Time-multiplexes one node MAC/activation datapath across NUM_PASSES neurons.
// Optional ACCUM stall input enabled by defining NODE_SEQ_PAUSE_EN.
module node_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = NN_NUM_INPUTS,
  parameter int unsigned NUM_PASSES = NN_NUM_PASSES,
  parameter int unsigned CNT_W      = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
`ifdef NODE_SEQ_PAUSE_EN
  input  logic             pause,
`endif
  output logic             reset_acc,
  output logic             hold,
  output logic [CNT_W-1:0] cnt_val,
  output logic [3:0]       pass_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  seq_state_t state_q, state_d;
  logic       pause_act;
  logic       cnt_last, pass_last;
  logic       cnt_clear, cnt_en, pass_clear, pass_en;

`ifdef NODE_SEQ_PAUSE_EN
  assign pause_act = pause;
`else
  assign pause_act = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StClear;
      StClear: state_d = StAccum;
      StAccum: if (cnt_last && !pause_act) state_d = StDone;
      StDone:  if (out_ready) state_d = pass_last ? StIdle : StClear;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Element index wraps to 0 on the last ACCUM edge, so it is already clean for the next pass.
  assign cnt_clear  = abort || (state_q == StIdle);
  assign cnt_en     = (state_q == StAccum) && !pause_act;
  assign pass_clear = abort || (state_q == StIdle) ||
                      ((state_q == StDone) && out_ready && pass_last);
  assign pass_en    = (state_q == StDone) && out_ready && !pass_last;

  seq_counter #(
    .Width (CNT_W)
  ) u_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (cnt_clear),
    .enable        (cnt_en),
    .rollover_val  (CNT_W'(NUM_INPUTS - 1)),
    .count         (cnt_val),
    .rollover_flag (cnt_last)
  );

  seq_counter #(
    .Width (4)
  ) u_pass (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (pass_clear),
    .enable        (pass_en),
    .rollover_val  (4'(NUM_PASSES - 1)),
    .count         (pass_idx),
    .rollover_flag (pass_last)
  );

  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    reset_acc = (state_q == StClear);
    hold      = !((state_q == StAccum) && !pause_act);
    out_valid = (state_q == StDone);
    out_last  = (state_q == StDone) && pass_last;
  end

endmodule

// File: tb/tb_node_sequencer.sv
// Randomised and directed bench for node_sequencer against a pass-position reference model.
module tb_node_sequencer;

  localparam int NA = 40;
  localparam int PA = 3;
  localparam int NB = 64;
  localparam int PB = 1;

  logic clk = 1'b0;
  logic n_rst, in_valid, abort, out_ready, pause, pause_eff;

  logic       a_ir, a_hold, a_ra, a_ov, a_ol, a_busy;
  logic [5:0] a_cnt;
  logic [3:0] a_pi;
  logic       b_ir, b_hold, b_ra, b_ov, b_ol, b_busy;
  logic [6:0] b_cnt;
  logic [3:0] b_pi;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pos 0 = clear cycle, 1..n = accumulate element pos-1, n+1 = result presented.
  typedef struct {
    bit active;
    int pos;
    int pass;
  } mdl_t;

  mdl_t ma, mb;

  always #5 clk = ~clk;

`ifdef NODE_SEQ_PAUSE_EN
  assign pause_eff = pause;
`else
  assign pause_eff = 1'b0;
`endif

  node_sequencer #(.NUM_INPUTS(NA), .NUM_PASSES(PA), .CNT_W(6)) dut_a (
    .clk (clk), .n_rst (n_rst), .in_valid (in_valid), .in_ready (a_ir), .abort (abort),
`ifdef NODE_SEQ_PAUSE_EN
    .pause (pause),
`endif
    .reset_acc (a_ra), .hold (a_hold), .cnt_val (a_cnt), .pass_idx (a_pi),
    .out_valid (a_ov), .out_ready (out_ready), .out_last (a_ol), .busy (a_busy)
  );

  node_sequencer #(.NUM_INPUTS(NB), .NUM_PASSES(PB), .CNT_W(7)) dut_b (
    .clk (clk), .n_rst (n_rst), .in_valid (in_valid), .in_ready (b_ir), .abort (abort),
`ifdef NODE_SEQ_PAUSE_EN
    .pause (pause),
`endif
    .reset_acc (b_ra), .hold (b_hold), .cnt_val (b_cnt), .pass_idx (b_pi),
    .out_valid (b_ov), .out_ready (out_ready), .out_last (b_ol), .busy (b_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_idle();
    mdl_t r;
    r.active = 1'b0;
    r.pos    = 0;
    r.pass   = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int n, input int p, input bit iv,
                                    input bit ordy, input bit ab, input bit ps);
    mdl_t r = m;
    if (ab) begin
      r = mdl_idle();
    end else if (!m.active) begin
      if (iv) begin
        r.active = 1'b1;
        r.pos    = 0;
        r.pass   = 0;
      end
    end else if (m.pos == 0) begin
      r.pos = 1;
    end else if (m.pos <= n) begin
      if (!ps) r.pos = m.pos + 1;
    end else if (ordy) begin
      if (m.pass == p - 1) begin
        r = mdl_idle();
      end else begin
        r.pass = m.pass + 1;
        r.pos  = 0;
      end
    end
    return r;
  endfunction

  task automatic check_outs(input string nm, input mdl_t m, input int n, input int p,
                            input logic ir, input logic hd, input logic ra, input logic [31:0] cnt,
                            input logic [3:0] pi, input logic ov, input logic ol, input logic bz);
    bit acc;
    bit e_ov;
    acc  = m.active && m.pos >= 1 && m.pos <= n;
    e_ov = m.active && m.pos == n + 1;
    check_eq({nm, ".in_ready"},  32'(ir),  32'(!m.active));
    check_eq({nm, ".busy"},      32'(bz),  32'(m.active));
    check_eq({nm, ".reset_acc"}, 32'(ra),  32'(m.active && m.pos == 0));
    check_eq({nm, ".hold"},      32'(hd),  32'(!(acc && !pause_eff)));
    check_eq({nm, ".cnt_val"},   cnt,      acc ? 32'(m.pos - 1) : 32'd0);
    check_eq({nm, ".pass_idx"},  32'(pi),  32'(m.pass));
    check_eq({nm, ".out_valid"}, 32'(ov),  32'(e_ov));
    check_eq({nm, ".out_last"},  32'(ol),  32'(e_ov && m.pass == p - 1));
  endtask

  task automatic check_all();
    check_outs("a", ma, NA, PA, a_ir, a_hold, a_ra, 32'(a_cnt), a_pi, a_ov, a_ol, a_busy);
    check_outs("b", mb, NB, PB, b_ir, b_hold, b_ra, 32'(b_cnt), b_pi, b_ov, b_ol, b_busy);
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (n_rst) begin
      ma = mdl_step(ma, NA, PA, in_valid, out_ready, abort, pause_eff);
      mb = mdl_step(mb, NB, PB, in_valid, out_ready, abort, pause_eff);
    end
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    ma = mdl_idle();
    mb = mdl_idle();
    check_all();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  task automatic accept();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    in_valid  = 1'b0;
    abort     = 1'b0;
    pause     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!ma.active && !mb.active) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  initial begin
    bit found;
    int wt;
    n_rst = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0; pause = 1'b0;
    ma = mdl_idle();
    mb = mdl_idle();

    repeat (3) @(posedge clk);
    #1;
    check_all();
    n_rst = 1'b1;
    tick();

    // Single vector, out_ready held high
    out_ready = 1'b1;
    accept();
    wait_idle("single_done");
    tick();

    // Backpressure: five stalled cycles in every DONE of dut_a
    accept();
    wt = 0;
    for (int i = 0; i < 600 && ma.active; i++) begin
      if (ma.pos == NA + 1 && wt < 5) begin
        out_ready = 1'b0;
        wt++;
      end else begin
        out_ready = 1'b1;
        wt = 0;
      end
      tick();
    end
    wait_idle("bp_done");

    // Abort at cnt_val 30 during pass 1
    accept();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ma.active && ma.pass == 1 && ma.pos == 31) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq("abort_reach", 32'(found), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (5) tick();
    wait_idle("abort_done");

`ifdef NODE_SEQ_PAUSE_EN
    accept();
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ma.active && ma.pos == 11) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq("pause_reach", 32'(found), 32'd1);
    pause = 1'b1;
    repeat (4) tick();
    pause = 1'b0;
    wait_idle("pause_done");
`endif

    // Asynchronous reset in the middle of ACCUM, then a fresh vector
    accept();
    repeat (20) tick();
    do_reset();
    tick();
    accept();
    wait_idle("post_reset_done");

    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom % 2);
      out_ready = ($urandom % 10) < 7;
      abort     = ($urandom % 50) == 0;
      pause     = ($urandom % 5) == 0;
      if (($urandom % 300) == 0) do_reset();
      tick();
    end
    wait_idle("random_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
